// File: rtl/counter_seq_checker.sv
// counter_seq_checker: receive-side monitor for a free-running up-counter bus.
// Locks onto the mod-2^WIDTH increment sequence from qualified samples, then
// flags wrap-around, counter restarts and sequence errors, and keeps a
// saturating error total.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   q_in          observed counter value (WIDTH bits)
//   q_valid       sample qualifier; q_in ignored when low
//   err_clr       synchronous clear of err_count
//   locked        high while in LOCKED or SLIP
//   expected      predicted next counter value
//   err_pulse     one-cycle pulse per counted sequence error
//   wrap_pulse    one-cycle pulse on a matched all-ones sample while locked
//   restart_pulse one-cycle pulse when the counter restarts at zero
//   err_count     saturating error total (ERR_CNT_W bits)

module counter_seq_checker #(
    parameter int WIDTH      = 4,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     q_in,
    input  logic                 q_valid,
    input  logic                 err_clr,
    output logic                 locked,
    output logic [WIDTH-1:0]     expected,
    output logic                 err_pulse,
    output logic                 wrap_pulse,
    output logic                 restart_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [1:0] ST_UNSYNC  = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [1:0] ST_SLIP    = 2'd3;

    localparam int GW = (LOCK_CNT   < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam int BW = (UNLOCK_CNT < 2) ? 1 : $clog2(UNLOCK_CNT + 1);

    localparam logic [GW-1:0]        GOOD_MAX = GW'(LOCK_CNT);
    localparam logic [BW-1:0]        BAD_MAX  = BW'(UNLOCK_CNT);
    localparam logic [WIDTH-1:0]     ALL_ONES = '1;
    localparam logic [WIDTH-1:0]     ZERO_VAL = '0;
    localparam logic [WIDTH-1:0]     ONE_VAL  = WIDTH'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

    // Registered state
    logic [1:0]    state;
    logic [GW-1:0] good_cnt;
    logic [BW-1:0] bad_cnt;

    // Next-state values
    logic [1:0]           state_nx;
    logic [GW-1:0]        good_nx;
    logic [BW-1:0]        bad_nx;
    logic [WIDTH-1:0]     exp_nx;
    logic                 err_nx;
    logic                 wrap_nx;
    logic                 restart_nx;
    logic                 locked_nx;
    logic [ERR_CNT_W-1:0] errc_nx;

    // Helpers
    logic [WIDTH-1:0] exp_inc;
    logic [WIDTH-1:0] seed;
    logic [GW-1:0]    good_inc;
    logic [BW-1:0]    bad_inc;
    logic             is_match;
    logic             is_restart;

    assign exp_inc  = expected + ONE_VAL;
    assign seed     = q_in + ONE_VAL;
    assign good_inc = good_cnt + GW'(1);
    assign bad_inc  = bad_cnt + BW'(1);
    assign is_match = (q_in == expected);

    // A zero sample against a nonzero prediction is a restart, which is
    // checked ahead of the error path so it never costs lock.
    assign is_restart = (q_in == ZERO_VAL) && (expected != ZERO_VAL);

    always_comb begin
        state_nx   = state;
        good_nx    = good_cnt;
        bad_nx     = bad_cnt;
        exp_nx     = expected;
        err_nx     = 1'b0;
        wrap_nx    = 1'b0;
        restart_nx = 1'b0;

        if (q_valid) begin
            unique case (state)
                ST_UNSYNC: begin
                    exp_nx  = seed;
                    good_nx = GW'(1);
                    bad_nx  = '0;
                    if (LOCK_CNT == 1) begin
                        state_nx = ST_LOCKED;
                    end else begin
                        state_nx = ST_ACQUIRE;
                    end
                end

                ST_ACQUIRE: begin
                    if (is_match) begin
                        exp_nx  = exp_inc;
                        good_nx = good_inc;
                        if (good_inc == GOOD_MAX) begin
                            state_nx = ST_LOCKED;
                        end
                    end else begin
                        // Re-seed from the new sample
                        exp_nx  = seed;
                        good_nx = GW'(1);
                    end
                end

                ST_LOCKED, ST_SLIP: begin
                    if (is_match) begin
                        exp_nx   = exp_inc;
                        wrap_nx  = (q_in == ALL_ONES);
                        bad_nx   = '0;
                        state_nx = ST_LOCKED;
                    end else if (is_restart) begin
                        restart_nx = 1'b1;
                        exp_nx     = ONE_VAL;
                        bad_nx     = '0;
                        state_nx   = ST_LOCKED;
                    end else begin
                        // Keep free-running the prediction so a single
                        // corrupted sample does not desynchronise us.
                        err_nx = 1'b1;
                        exp_nx = exp_inc;
                        if (state == ST_LOCKED) begin
                            bad_nx = BW'(1);
                        end else begin
                            bad_nx = bad_inc;
                        end
                        if (bad_nx == BAD_MAX) begin
                            state_nx = ST_UNSYNC;
                            exp_nx   = '0;
                            bad_nx   = '0;
                            good_nx  = '0;
                        end else begin
                            state_nx = ST_SLIP;
                        end
                    end
                end
            endcase
        end
    end

    assign locked_nx = (state_nx == ST_LOCKED) ||
                       (state_nx == ST_SLIP);

    // A clear in the same cycle as a counted error leaves that error counted.
    always_comb begin
        errc_nx = err_count;
        if (err_clr) begin
            errc_nx = err_nx ? ERR_CNT_W'(1) : '0;
        end else if (err_nx && (err_count != ERR_MAX)) begin
            errc_nx = err_count + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_UNSYNC;
            good_cnt      <= '0;
            bad_cnt       <= '0;
            expected      <= '0;
            locked        <= 1'b0;
            err_pulse     <= 1'b0;
            wrap_pulse    <= 1'b0;
            restart_pulse <= 1'b0;
            err_count     <= '0;
        end else begin
            state         <= state_nx;
            good_cnt      <= good_nx;
            bad_cnt       <= bad_nx;
            expected      <= exp_nx;
            locked        <= locked_nx;
            err_pulse     <= err_nx;
            wrap_pulse    <= wrap_nx;
            restart_pulse <= restart_nx;
            err_count     <= errc_nx;
        end
    end

endmodule

// File: tb/tb_counter_seq_checker.sv
// tb_counter_seq_checker: directed bench for counter_seq_checker.
// Two instances (8-bit and 2-bit error counters) share one stimulus stream.

module tb_counter_seq_checker;

    localparam int W  = 4;
    localparam int M  = 1 << W;
    localparam int LK = 3;
    localparam int UL = 2;

    logic         clk;
    logic         rst;
    logic [W-1:0] q_in;
    logic         q_valid;
    logic         err_clr;

    logic         a_locked, a_err, a_wrap, a_rest;
    logic [W-1:0] a_exp;
    logic [7:0]   a_cnt;
    logic         b_locked, b_err, b_wrap, b_rest;
    logic [W-1:0] b_exp;
    logic [1:0]   b_cnt;

    counter_seq_checker #(
        .WIDTH(W), .LOCK_CNT(LK), .UNLOCK_CNT(UL), .ERR_CNT_W(8)
    ) dut_a (
        .clk(clk), .rst(rst), .q_in(q_in), .q_valid(q_valid),
        .err_clr(err_clr), .locked(a_locked), .expected(a_exp),
        .err_pulse(a_err), .wrap_pulse(a_wrap),
        .restart_pulse(a_rest), .err_count(a_cnt)
    );

    counter_seq_checker #(
        .WIDTH(W), .LOCK_CNT(LK), .UNLOCK_CNT(UL), .ERR_CNT_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .q_in(q_in), .q_valid(q_valid),
        .err_clr(err_clr), .locked(b_locked), .expected(b_exp),
        .err_pulse(b_err), .wrap_pulse(b_wrap),
        .restart_pulse(b_rest), .err_count(b_cnt)
    );

    int checks = 0;
    int passes = 0;

    // Behavioural model: mode 0 unsync, 1 acquiring, 2 locked, 3 slipping
    int mode = 0;
    int run_good = 0;
    int run_bad = 0;
    int m_exp = 0;
    int m_err = 0;
    int m_wrap = 0;
    int m_rest = 0;
    int m_lock = 0;
    int c8 = 0;
    int c2 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, req);
    endtask

    task automatic model_step();
        int v;
        if (rst) begin
            mode = 0; run_good = 0; run_bad = 0; m_exp = 0;
            m_err = 0; m_wrap = 0; m_rest = 0; m_lock = 0;
            c8 = 0; c2 = 0;
            return;
        end
        m_err = 0; m_wrap = 0; m_rest = 0;
        if (q_valid) begin
            v = int'(q_in);
            case (mode)
                0: begin
                    m_exp = (v + 1) % M;
                    run_good = 1;
                    mode = (LK == 1) ? 2 : 1;
                end
                1: begin
                    if (v == m_exp) begin
                        run_good += 1;
                        m_exp = (m_exp + 1) % M;
                        if (run_good >= LK) mode = 2;
                    end else begin
                        run_good = 1;
                        m_exp = (v + 1) % M;
                    end
                end
                default: begin
                    if (v == m_exp) begin
                        m_wrap = (v == M - 1) ? 1 : 0;
                        m_exp = (m_exp + 1) % M;
                        run_bad = 0;
                        mode = 2;
                    end else if (v == 0) begin
                        m_rest = 1;
                        m_exp = 1;
                        run_bad = 0;
                        mode = 2;
                    end else begin
                        m_err = 1;
                        run_bad += 1;
                        m_exp = (m_exp + 1) % M;
                        mode = 3;
                        if (run_bad >= UL) begin
                            mode = 0; m_exp = 0;
                            run_bad = 0; run_good = 0;
                        end
                    end
                end
            endcase
        end
        m_lock = (mode >= 2) ? 1 : 0;
        if (err_clr) begin
            c8 = m_err;
            c2 = m_err;
        end else if (m_err == 1) begin
            if (c8 < 255) c8++;
            if (c2 < 3) c2++;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // Compare process: every falling edge, both DUTs against the model
    initial forever begin
        @(negedge clk);
        chk("a_locked", a_locked, m_lock);
        chk("a_expected", a_exp, m_exp);
        chk("a_err_pulse", a_err, m_err);
        chk("a_wrap_pulse", a_wrap, m_wrap);
        chk("a_restart_pulse", a_rest, m_rest);
        chk("a_err_count", a_cnt, c8);
        chk("b_locked", b_locked, m_lock);
        chk("b_expected", b_exp, m_exp);
        chk("b_err_pulse", b_err, m_err);
        chk("b_err_count", b_cnt, c2);
    end

    task automatic smp(input int v, input bit vld = 1'b1,
                       input bit clr = 1'b0);
        q_in = W'(v);
        q_valid = vld;
        err_clr = clr;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        q_in = '0;
        q_valid = 1'b0;
        err_clr = 1'b0;
        #12;
        chk("rst_locked", a_locked, 0);
        chk("rst_expected", a_exp, 0);
        chk("rst_err_count", a_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // Acquire and lock on 0,1,2
        smp(0);
        smp(1);
        chk("acq_not_locked", a_locked, 0);
        smp(2);
        chk("lock_locked", a_locked, 1);
        chk("lock_expected", a_exp, 3);
        chk("lock_no_wrap", a_wrap, 0);
        chk("lock_no_err", a_err, 0);

        // Run up to the wrap
        for (int v = 3; v < 15; v++) smp(v);
        smp(15);
        chk("wrap_pulse", a_wrap, 1);
        smp(0);
        chk("wrap_once", a_wrap, 0);
        chk("wrap_no_restart", a_rest, 0);
        chk("wrap_expected", a_exp, 1);
        chk("wrap_err_count", a_cnt, 0);

        // Invalid sample holds everything
        smp(9, 1'b0);
        chk("hold_expected", a_exp, 1);
        chk("hold_locked", a_locked, 1);

        // Restart with expected 7
        for (int v = 1; v < 7; v++) smp(v);
        smp(0);
        chk("restart_pulse", a_rest, 1);
        chk("restart_expected", a_exp, 1);
        chk("restart_locked", a_locked, 1);
        chk("restart_err_count", a_cnt, 0);
        smp(1);
        chk("restart_one_cycle", a_rest, 0);

        // Single error then recovery from SLIP
        for (int v = 2; v < 5; v++) smp(v);
        smp(9);
        chk("slip_err_pulse", a_err, 1);
        chk("slip_err_count", a_cnt, 1);
        chk("slip_locked", a_locked, 1);
        chk("slip_expected", a_exp, 6);
        smp(6);
        chk("slip_recover_locked", a_locked, 1);
        chk("slip_recover_expected", a_exp, 7);

        // Two errors drop lock, then relock on 3,4,5
        for (int v = 7; v < 21; v++) smp(v % M);
        smp(9);
        smp(9);
        chk("unlock_locked", a_locked, 0);
        chk("unlock_err_count", a_cnt, 3);
        chk("unlock_expected", a_exp, 0);
        smp(3);
        smp(4);
        smp(5);
        chk("relock_locked", a_locked, 1);
        chk("relock_expected", a_exp, 6);

        // Fourth and fifth errors saturate the 2-bit counter
        smp(9);
        smp(7);
        smp(11);
        chk("sat_b_pulse", b_err, 1);
        chk("sat_b_count", b_cnt, 3);
        chk("sat_a_count", a_cnt, 5);
        smp(9);

        // Clear with and without a same-cycle error
        smp(3, 1'b1, 1'b1);
        chk("clr_err_a", a_cnt, 1);
        chk("clr_err_b", b_cnt, 1);
        smp(0, 1'b0, 1'b1);
        chk("clr_only_a", a_cnt, 0);
        chk("clr_only_b", b_cnt, 0);

        // Restart seen while slipping
        smp(11);
        smp(4);
        smp(0);
        chk("slip_restart_pulse", a_rest, 1);
        chk("slip_restart_expected", a_exp, 1);
        chk("slip_restart_locked", a_locked, 1);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        chk("async_locked", a_locked, 0);
        chk("async_expected", a_exp, 0);
        chk("async_err_count", a_cnt, 0);
        chk("async_b_count", b_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        smp(5);
        chk("post_rst_locked", a_locked, 0);
        chk("post_rst_expected", a_exp, 6);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
